// File: rtl/controller_state_machine_if.sv
// Control-unit bus of the 16-bit CPU.
// Carries the instruction-ROM fetch path (PC_Out -> instruction) and every
// control/observation output that the controller drives.
//   master : the controller (drives PC, IR, state codes and datapath controls)
//   slave  : the environment (instruction ROM, register file, ALU, data memory)
interface controller_state_machine_if #(
  parameter int unsigned PC_W    = 7,
  parameter int unsigned DADDR_W = 8
);
  logic [15:0]        instruction;
  logic [PC_W-1:0]    PC_Out;
  logic [15:0]        IR_Out;
  logic [3:0]         CurrentStateOut;
  logic [3:0]         NextStateOut;
  logic [DADDR_W-1:0] DAddr;
  logic               DWrite;
  logic               RFSelect;
  logic               RFWriteEnable;
  logic [3:0]         RFAReadAddr;
  logic [3:0]         RFBReadAddr;
  logic [3:0]         RFWriteAddr;
  logic [2:0]         ALUSelect;

  modport master (
    input  instruction,
    output PC_Out, IR_Out, CurrentStateOut, NextStateOut,
    output DAddr, DWrite, RFSelect, RFWriteEnable,
    output RFAReadAddr, RFBReadAddr, RFWriteAddr, ALUSelect
  );

  modport slave (
    output instruction,
    input  PC_Out, IR_Out, CurrentStateOut, NextStateOut,
    input  DAddr, DWrite, RFSelect, RFWriteEnable,
    input  RFAReadAddr, RFBReadAddr, RFWriteAddr, ALUSelect
  );
endinterface

// File: rtl/controller_state_machine.sv
// Control unit of the 16-bit CPU: program counter, instruction register and
// Moore sequencing FSM for NOOP/STORE/LOAD/ADD/SUB/HALT.
// Ports:
//   Clk  : single clock, all state updates on the rising edge
//   Rst  : asynchronous active-low reset (state Init, PC 0, IR 0)
//   bus  : controller_state_machine_if.master -- instruction in; PC_Out,
//          IR_Out, current/next state codes and datapath controls out
// All control outputs depend only on the current state and IR.
module controller_state_machine #(
  parameter int unsigned PC_W    = 7,
  parameter int unsigned DADDR_W = 8
) (
  input  logic                          Clk,
  input  logic                          Rst,
  controller_state_machine_if.master    bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, PC and IR update. PC moves only in Init/Fetch, IR loads only
  // in Fetch, so Halt freezes both simply by holding state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_INIT: begin
        pc_d    = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = bus.instruction;
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode_t'(ir_q[15:12]))
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOADA;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;
        endcase
      end
      S_LOADA:                                  state_d = S_LOADB;
      S_NOOP, S_LOADB, S_STORE, S_ADD, S_SUB:   state_d = S_FETCH;
      S_HALT:                                   state_d = S_HALT;
      default:                                  state_d = S_INIT;
    endcase
  end

  // Moore control outputs
  always_comb begin
    bus.DAddr         = '0;
    bus.DWrite        = 1'b0;
    bus.RFSelect      = 1'b0;
    bus.RFWriteEnable = 1'b0;
    bus.RFAReadAddr   = '0;
    bus.RFBReadAddr   = '0;
    bus.RFWriteAddr   = '0;
    bus.ALUSelect     = '0;
    case (state_q)
      S_LOADA, S_LOADB: begin
        bus.DAddr         = ir_q[4 +: DADDR_W];
        bus.RFSelect      = 1'b1;
        bus.RFWriteAddr   = ir_q[3:0];
        bus.RFWriteEnable = (state_q == S_LOADB);
      end
      S_STORE: begin
        bus.DAddr       = ir_q[4 +: DADDR_W];
        bus.RFAReadAddr = ir_q[3:0];
        bus.DWrite      = 1'b1;
      end
      S_ADD, S_SUB: begin
        bus.RFAReadAddr   = ir_q[11:8];
        bus.RFBReadAddr   = ir_q[7:4];
        bus.RFWriteAddr   = ir_q[3:0];
        bus.RFWriteEnable = 1'b1;
        bus.ALUSelect     = (state_q == S_ADD) ? 3'd1 : 3'd2;
      end
      default: ;
    endcase
  end

  assign bus.PC_Out          = pc_q;
  assign bus.IR_Out          = ir_q;
  assign bus.CurrentStateOut = state_q;
  assign bus.NextStateOut    = state_d;

endmodule

// File: tb/tb_controller_state_machine.sv
module tb_controller_state_machine;

  logic Clk;
  logic Rst;

  controller_state_machine_if #(.PC_W(7), .DADDR_W(8)) bus ();

  controller_state_machine #(.PC_W(7), .DADDR_W(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instruction ROM with one cycle of read latency
  logic [15:0] mem [128];
  always @(posedge Clk) bus.instruction <= mem[bus.PC_Out];

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: executes the program one instruction at a time and
  // queues the cycle-by-cycle observations that instruction should produce.
  typedef struct {
    int          st;
    int          pc;
    logic [15:0] ir;
  } rec_t;

  rec_t exp_q[$];
  int          m_pc;
  logic [15:0] m_ir;
  bit          m_halted;
  int          halt_cycles;

  function automatic rec_t mk(input int st, input int pc, input logic [15:0] ir);
    rec_t r;
    r.st = st; r.pc = pc; r.ir = ir;
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc = 0; m_ir = 16'h0000; m_halted = 0; halt_cycles = 0;
    exp_q.push_back(mk(0, 0, 16'h0000));
  endtask

  task automatic refill();
    int op;
    while (exp_q.size() < 2) begin
      if (m_halted) begin
        exp_q.push_back(mk(9, m_pc, m_ir));
      end else begin
        exp_q.push_back(mk(1, m_pc, m_ir));
        m_ir = mem[m_pc];
        m_pc = (m_pc + 1) % 128;
        exp_q.push_back(mk(2, m_pc, m_ir));
        op = int'(m_ir[15:12]);
        if (op == 1) exp_q.push_back(mk(6, m_pc, m_ir));
        else if (op == 2) begin
          exp_q.push_back(mk(4, m_pc, m_ir));
          exp_q.push_back(mk(5, m_pc, m_ir));
        end
        else if (op == 3) exp_q.push_back(mk(7, m_pc, m_ir));
        else if (op == 4) exp_q.push_back(mk(8, m_pc, m_ir));
        else if (op == 5) begin
          exp_q.push_back(mk(9, m_pc, m_ir));
          m_halted = 1;
        end
        else exp_q.push_back(mk(3, m_pc, m_ir));
      end
    end
  endtask

  // Expected {DAddr,DWrite,RFSelect,RFWriteEnable,RA,RB,RW,ALUSelect}
  function automatic logic [25:0] ctrl_of(input int st, input logic [15:0] ir);
    logic [25:0] c;
    c = '0;
    if (st == 4 || st == 5)
      c = {ir[11:4], 1'b0, 1'b1, (st == 5), 4'h0, 4'h0, ir[3:0], 3'd0};
    else if (st == 6)
      c = {ir[11:4], 1'b1, 1'b0, 1'b0, ir[3:0], 4'h0, 4'h0, 3'd0};
    else if (st == 7 || st == 8)
      c = {8'h00, 1'b0, 1'b0, 1'b1, ir[11:8], ir[7:4], ir[3:0], (st == 7) ? 3'd1 : 3'd2};
    return c;
  endfunction

  function automatic logic [25:0] ctrl_obs();
    return {bus.DAddr, bus.DWrite, bus.RFSelect, bus.RFWriteEnable,
            bus.RFAReadAddr, bus.RFBReadAddr, bus.RFWriteAddr, bus.ALUSelect};
  endfunction

  task automatic check_cycle();
    rec_t r;
    refill();
    r = exp_q.pop_front();
    if (r.st == 9) halt_cycles++;
    chk("state", 32'(bus.CurrentStateOut), 32'(r.st));
    chk("next_state", 32'(bus.NextStateOut), 32'(exp_q[0].st));
    chk("pc", 32'(bus.PC_Out), 32'(r.pc));
    chk("ir", 32'(bus.IR_Out), 32'(r.ir));
    chk("ctrl", 32'(ctrl_obs()), 32'(ctrl_of(r.st, r.ir)));
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    model_reset();
    check_cycle();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge Clk);
      check_cycle();
    end
  endtask

  // Assert reset away from any clock edge; state, PC and IR must clear at once.
  task automatic async_reset_check();
    @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk("async_rst_state", 32'(bus.CurrentStateOut), 32'd0);
    chk("async_rst_pc", 32'(bus.PC_Out), 32'd0);
    chk("async_rst_ir", 32'(bus.IR_Out), 32'd0);
    chk("async_rst_ctrl", 32'(ctrl_obs()), 32'd0);
  endtask

  task automatic run_to_halt(input string tag);
    int budget;
    budget = 0;
    while (!(m_halted && halt_cycles >= 20) && budget < 1000) begin
      @(negedge Clk);
      check_cycle();
      budget++;
    end
    chk({tag, "_halt_reached"}, 32'(halt_cycles >= 20), 32'd1);
    chk({tag, "_halt_state"}, 32'(bus.CurrentStateOut), 32'd9);
  endtask

  initial begin
    int op;
    Rst = 1'b0;

    // Directed program: NOOP, LOAD, STORE, ADD, SUB, unknown op, HALT
    foreach (mem[i]) mem[i] = 16'h0000;
    mem[0] = 16'h0000; mem[1] = 16'h21B5; mem[2] = 16'h1C47;
    mem[3] = 16'h3123; mem[4] = 16'h4123; mem[5] = 16'hF000;
    mem[6] = 16'h5000;
    do_reset();
    run_to_halt("directed");
    async_reset_check();

    // Long non-halting random stream: PC must wrap 127 -> 0
    foreach (mem[i]) begin
      op = $urandom_range(0, 14);
      if (op >= 5) op++;
      mem[i] = {4'(op), 12'($urandom)};
    end
    do_reset();
    run(700);
    async_reset_check();

    // Random programs ending at a HALT
    for (int p = 0; p < 4; p++) begin
      foreach (mem[i]) mem[i] = 16'($urandom);
      mem[$urandom_range(10, 120)] = 16'h5000;
      do_reset();
      run_to_halt("random");
      async_reset_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
